// File: rtl/sram_arbiter.sv
// Arbitrates one 32-bit asynchronous SRAM between a read-only fetch port and a byte/half/word data port.
// Define SRAM_ARB_FAIR_EN to force a waiting fetch through after FAIR_LIMIT consecutive data grants.
module sram_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned FAIR_LIMIT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_sel,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic [19:0] sram_addr,
    input  logic [31:0] sram_dq_i,
    output logic [31:0] sram_dq_o,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic [3:0]  sram_be_n,
    output logic        busy
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_WR_HOLD,
        ST_DONE
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("sram_arbiter: WAIT_CYCLES must be within 1..15");
    end
    if (FAIR_LIMIT < 1 || FAIR_LIMIT > 255) begin : g_bad_fair
        $error("sram_arbiter: FAIR_LIMIT must be within 1..255");
    end

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic        data_id_q, data_id_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  off_q, off_d;
    logic [19:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;

    logic grant_data;
    logic grant_fetch;
    logic force_fetch;

    // Only the word-address bits reach the SRAM; fetches are always whole words.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:22], if_addr[1:0], d_addr[31:22]};

    function automatic logic [3:0] lane_be(input logic [1:0] sel, input logic [1:0] off);
        case (sel)
            2'b01:   return ~(4'b0001 << off);
            2'b10:   return off[1] ? 4'b0011 : 4'b1100;
            2'b11:   return 4'b0000;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the store data puts it in every candidate lane; be_n picks the real one.
    function automatic logic [31:0] lane_wdata(input logic [1:0] sel, input logic [31:0] wdata);
        case (sel)
            2'b01:   return {4{wdata[7:0]}};
            2'b10:   return {2{wdata[15:0]}};
            2'b11:   return wdata;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] lane_rdata(input logic [1:0] sel, input logic [1:0] off,
                                               input logic [31:0] word);
        logic [31:0] shifted;
        shifted = 32'h0;
        case (sel)
            2'b01: begin
                shifted = word >> {off, 3'b000};
                return {24'h0, shifted[7:0]};
            end
            2'b10: begin
                shifted = word >> {off[1], 4'b0000};
                return {16'h0, shifted[15:0]};
            end
            2'b11:   return word;
            default: return 32'h0;
        endcase
    endfunction

`ifdef SRAM_ARB_FAIR_EN
    localparam logic [7:0] FAIR_MAX = 8'(FAIR_LIMIT);
    logic [7:0] fair_q, fair_d;

    assign force_fetch = if_req && (fair_q >= FAIR_MAX);

    always_comb begin
        fair_d = fair_q;
        if (grant_fetch) begin
            fair_d = 8'd0;
        end else if (grant_data && if_req) begin
            fair_d = fair_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fair_q <= 8'd0;
        end else begin
            fair_q <= fair_d;
        end
    end
`else
    assign force_fetch = 1'b0;
`endif

    assign grant_data  = (state_q == ST_IDLE) && d_req && !force_fetch;
    assign grant_fetch = (state_q == ST_IDLE) && if_req && !grant_data;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        data_id_d = data_id_q;
        sel_d     = sel_q;
        off_d     = off_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        case (state_q)
            ST_IDLE: begin
                wait_d = 4'd0;
                if (grant_data) begin
                    data_id_d = 1'b1;
                    sel_d     = d_sel;
                    off_d     = d_addr[1:0];
                    addr_d    = d_addr[21:2];
                    be_d      = lane_be(d_sel, d_addr[1:0]);
                    wdata_d   = lane_wdata(d_sel, d_wdata);
                    rdata_d   = 32'h0;
                    if (d_sel == 2'b00) begin
                        state_d = ST_DONE;
                    end else if (d_we) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end else if (grant_fetch) begin
                    data_id_d = 1'b0;
                    sel_d     = 2'b11;
                    off_d     = 2'b00;
                    addr_d    = if_addr[21:2];
                    be_d      = 4'b0000;
                    wdata_d   = 32'h0;
                    rdata_d   = 32'h0;
                    state_d   = ST_RD;
                end
            end
            ST_RD: begin
                if (wait_q == WAIT_LAST) begin
                    rdata_d = lane_rdata(sel_q, off_q, sram_dq_i);
                    state_d = ST_DONE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_WR: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_WR_HOLD: state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            wait_q    <= 4'd0;
            data_id_q <= 1'b0;
            sel_q     <= 2'b00;
            off_q     <= 2'b00;
            addr_q    <= 20'h0;
            wdata_q   <= 32'h0;
            be_q      <= 4'hF;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            data_id_q <= data_id_d;
            sel_q     <= sel_d;
            off_q     <= off_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_be_n  = 4'hF;
        sram_dq_oe = 1'b0;
        case (state_q)
            ST_RD: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_be_n = 4'b0000;
            end
            ST_WR: begin
                sram_ce_n  = 1'b0;
                sram_we_n  = 1'b0;
                sram_dq_oe = 1'b1;
                sram_be_n  = be_q;
            end
            // we_n rises while ce_n, address and data stay put to meet data hold time.
            ST_WR_HOLD: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
                sram_be_n  = be_q;
            end
            default: ;
        endcase
    end

    assign sram_addr = addr_q;
    assign sram_dq_o = wdata_q;
    assign if_ack    = (state_q == ST_DONE) && !data_id_q;
    assign d_ack     = (state_q == ST_DONE) && data_id_q;
    assign if_rdata  = if_ack ? rdata_q : 32'h0;
    assign d_rdata   = d_ack ? rdata_q : 32'h0;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one 32-bit asynchronous SRAM between instruction fetch (read-only) and the MEM stage data port (read/write, byte/half/word).
- Sequences the SRAM control strobes over a fixed number of wait cycles and returns data with a one-cycle ack pulse.
- Replaces the per-half read_ce/write_ce/rfin/wfin handshake with a single arbitrated req/ack per requester.

Parameters:
- WAIT_CYCLES, 2: cycles the strobes stay active per access (legal range 1..15).
- FAIR_LIMIT, 4: consecutive data grants before a waiting fetch is forced through (used only with SRAM_ARB_FAIR_EN).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetch data, valid while if_ack=1
- if_ack  out  1  one-cycle completion pulse
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1=store, 0=load
- d_sel  in  2  00 none, 01 byte, 10 half, 11 word
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-aligned
- d_rdata  out  32  load data, right-aligned, zero-extended, valid while d_ack=1
- d_ack  out  1  one-cycle completion pulse
- sram_addr  out  20  word address = addr[21:2]
- sram_dq_i  in  32  SRAM read data
- sram_dq_o  out  32  SRAM write data
- sram_dq_oe  out  1  tri-state enable for dq (pad owned by top level)
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low strobes
- sram_be_n  out  4  active-low byte enables
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0 at clk edge):
  - State goes to IDLE.
  - ce_n, oe_n and we_n are 1; be_n=4'hF; dq_oe=0.
  - sram_addr=0, sram_dq_o=0, acks=0, if_rdata=0, d_rdata=0, busy=0.
  - An access in flight when reset arrives is abandoned and never acked.
- States: IDLE, RD, WR, WR_HOLD, DONE. A wait counter counts 0..WAIT_CYCLES-1.
- IDLE arbitration:
  - Data has priority over fetch.
  - On grant, latch requester id, address, we, sel and lane-shifted wdata, and drive sram_addr.
  - d_sel=00 grants straight to DONE with no strobes (null access, d_rdata=0).
  - Loads and fetches go to RD. Stores go to WR.
- RD: ce_n=0, oe_n=0, be_n=0000, for WAIT_CYCLES cycles. On the final RD edge, capture sram_dq_i and go to DONE.
- WR: ce_n=0, we_n=0, dq_oe=1, be_n from lane decode, for WAIT_CYCLES cycles, then go to WR_HOLD.
- WR_HOLD: one cycle with we_n=1 and ce_n=0, dq_oe=1 and address held (data hold time), then go to DONE.
- DONE:
  - Strobes are inactive.
  - Pulse if_ack or d_ack for exactly one cycle with rdata valid.
  - Next state is always IDLE, so the acked requester can drop req before the next arbitration.
  - A req still high in the cycle after the ack is treated as a new request.
- Latency, with req seen in IDLE at cycle 0:
  - Read ack at cycle WAIT_CYCLES+1.
  - Store ack at cycle WAIT_CYCLES+2.
  - Null access ack at cycle 1.
- Lane rules (little-endian), off = addr[1:0]:
  - Byte: be_n bit off = 0; sram_dq_o = wdata[7:0] in lane off; load result = {24'h0, byte at lane off}.
  - Half: lanes {off[1]*2+1, off[1]*2}; off[0] is ignored (no alignment trap in this block).
  - Word: be_n=0000, and addr[1:0] is ignored.
- Simultaneous if_req and d_req in IDLE: data wins. Fetch stays pending and is granted at the next IDLE.
- Operand changes while not in IDLE are ignored, because all operands are latched at grant.
- The two ack outputs are never high in the same cycle.

Optional Feature:
- Macro: SRAM_ARB_FAIR_EN.
- When defined:
  - A counter counts consecutive data grants made while if_req=1.
  - When the counter reaches FAIR_LIMIT, the next IDLE arbitration grants fetch even if d_req=1, and the counter clears.
  - The counter also clears on any fetch grant and on reset.
- When undefined: strict data priority; fetch can starve indefinitely.

Test Plan:
- Fetch, WAIT_CYCLES=2: if_req, if_addr=0x0000_0010, SRAM returns 0xDEADBEEF. Expect sram_addr=0x00004, oe_n low cycles 1-2, if_ack in cycle 3 with if_rdata=0xDEADBEEF.
- Byte store: d_we=1, d_sel=01, d_addr=0x...0003, d_wdata=0x000000A5. Expect be_n=0111, sram_dq_o[31:24]=A5, we_n low 2 cycles then 1 hold cycle, d_ack in cycle 4.
- Half load: d_sel=10, d_addr=0x...0002, SRAM=0x1234ABCD. Expect d_rdata=0x00001234.
- Contention: if_req and d_req both rise in the same cycle. Expect data serviced first (d_ack), then IDLE, then fetch granted; acks never overlap.
- Reset mid-access: rst=0 during the second WR cycle. Expect all strobes high and dq_oe=0 the next cycle, no ack, state IDLE.
- SRAM_ARB_FAIR_EN with FAIR_LIMIT=4: d_req and if_req held high continuously. Expect exactly 4 d_acks, then 1 if_ack, repeating; without the macro, no if_ack.
